// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register offsets, bus widths and a
// byte-strobe expansion helper.
package gpio_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned OFF_W  = 8;

    localparam logic [OFF_W-1:0] GPIO_OUT  = 8'h00;
    localparam logic [OFF_W-1:0] GPIO_SET  = 8'h04;
    localparam logic [OFF_W-1:0] GPIO_CLR  = 8'h08;
    localparam logic [OFF_W-1:0] GPIO_TGL  = 8'h0C;
    localparam logic [OFF_W-1:0] GPIO_DIR  = 8'h10;
    localparam logic [OFF_W-1:0] GPIO_IN   = 8'h14;
    localparam logic [OFF_W-1:0] GPIO_RISE = 8'h18;
    localparam logic [OFF_W-1:0] GPIO_FALL = 8'h1C;
    localparam logic [OFF_W-1:0] GPIO_STAT = 8'h20;

    // Expand the four byte strobes into a 32-bit lane mask.
    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser followed by a one-cycle rise/fall detector.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_stage[0] <= i_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank on the picorv32 native bus: output register with
// atomic set/clear/toggle, direction, synchronised inputs and edge interrupts.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0200_0100,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  RESET_OUT   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_dir;
    logic [WIDTH-1:0]  r_rise_en;
    logic [WIDTH-1:0]  r_fall_en;
    logic [WIDTH-1:0]  r_stat;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_irq;

    logic              w_sel;
    logic              w_acc;
    logic              w_wr;
    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_mask32;
    logic [WIDTH-1:0]  w_bits;
    logic [WIDTH-1:0]  w_bm;
    logic [WIDTH-1:0]  w_w1c;
    logic [WIDTH-1:0]  w_stat_nxt;
    logic [DATA_W-1:0] w_rdata;
    logic [WIDTH-1:0]  w_sync;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_fall;
    logic              w_unused;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_pins (gpio_in),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Access happens once, on the edge where the request is seen and not yet acked.
    assign w_sel    = mem_valid && (mem_addr[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
    assign w_acc    = w_sel && !r_ready;
    assign w_wr     = w_acc && (mem_wstrb != '0);
    assign w_off    = mem_addr[OFF_W-1:0];
    assign w_mask32 = strb_to_mask(mem_wstrb);
    assign w_bm     = w_mask32[WIDTH-1:0];
    assign w_bits   = mem_wdata[WIDTH-1:0] & w_bm;
    assign w_unused = ^{mem_wdata, w_mask32};

    // A fresh edge outranks a simultaneous write-1-clear of the same bit.
    assign w_w1c      = (w_wr && (w_off == GPIO_STAT)) ? w_bits : '0;
    assign w_stat_nxt = (r_stat & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            GPIO_OUT:  w_rdata = DATA_W'(r_out);
            GPIO_DIR:  w_rdata = DATA_W'(r_dir);
            GPIO_IN:   w_rdata = DATA_W'(w_sync);
            GPIO_RISE: w_rdata = DATA_W'(r_rise_en);
            GPIO_FALL: w_rdata = DATA_W'(r_fall_en);
            GPIO_STAT: w_rdata = DATA_W'(r_stat);
            default:   w_rdata = '0;
        endcase
    end

    // Bus handshake: one-cycle ready, rdata held at zero outside the ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= RESET_OUT;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_off)
                GPIO_OUT:  r_out     <= (r_out & ~w_bm) | w_bits;
                GPIO_SET:  r_out     <= r_out | w_bits;
                GPIO_CLR:  r_out     <= r_out & ~w_bits;
                GPIO_TGL:  r_out     <= r_out ^ w_bits;
                GPIO_DIR:  r_dir     <= (r_dir & ~w_bm) | w_bits;
                GPIO_RISE: r_rise_en <= (r_rise_en & ~w_bm) | w_bits;
                GPIO_FALL: r_fall_en <= (r_fall_en & ~w_bm) | w_bits;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= w_stat_nxt;
            r_irq  <= |w_stat_nxt;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_dir;
    assign irq       = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: an 8-bit and a 16-bit instance share one bus.
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'h0200_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [7:0]  gpio_in8 = '0;
    logic [15:0] gpio_in16;

    logic        ready8, ready16, irq8, irq16;
    logic [31:0] rdata8, rdata16;
    logic [7:0]  out8, oe8;
    logic [15:0] out16, oe16;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] r8, r16;

    assign gpio_in16 = {8'h00, gpio_in8};

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready8),
        .mem_rdata(rdata8), .gpio_in(gpio_in8), .gpio_out(out8), .gpio_oe(oe8),
        .irq(irq8)
    );

    gpio_bank #(.WIDTH(16), .RESET_OUT(16'h5A5A)) dut16 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready16),
        .mem_rdata(rdata16), .gpio_in(gpio_in16), .gpio_out(out16), .gpio_oe(oe16),
        .irq(irq16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; returns both instances' read data and checks the ack shape.
    task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] o8, output logic [31:0] o16);
        logic seen;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE | 32'(off);
        mem_wdata = wd;
        mem_wstrb = ws;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (ready8) seen = 1'b1;
        end
        chk("ack", 32'(seen), 32'd1);
        chk("ack16", 32'(ready16), 32'd1);
        o8  = rdata8;
        o16 = rdata16;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        @(negedge clk);
        chk("ready_one_cycle", 32'(ready8), 32'd0);
        chk("rdata_idle_zero", rdata8 | rdata16, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [7:0] off,
                      input logic [31:0] e8, input logic [31:0] e16);
        logic [31:0] a, b;
        bus(off, 32'h0, 4'h0, a, b);
        chk({tag, "_w8"}, a, e8);
        chk({tag, "_w16"}, b, e16);
    endtask

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(ready8), 32'd0);
        chk("rst_irq", 32'({irq8, irq16}), 32'd0);
        chk("rst_out8", 32'(out8), 32'h00);
        chk("rst_out16", 32'(out16), 32'h5A5A);
        chk("rst_oe", 32'({oe16, oe8}), 32'd0);

        rd("rst_out", 8'h00, 32'h0, 32'h5A5A);
        for (int o = 4; o <= 32; o += 4) rd("rst_reg", 8'(o), 32'h0, 32'h0);

        gpio_in8 = 8'h02;
        repeat (5) @(negedge clk);
        rd("in", 8'h14, 32'h02, 32'h02);

        bus(8'h00, 32'hA5, 4'hF, r8, r16);
        chk("gpio_out_a5", 32'(out8), 32'hA5);
        chk("gpio_out16_a5", 32'(out16), 32'h00A5);
        rd("out_a5", 8'h00, 32'hA5, 32'hA5);
        bus(8'h04, 32'h0F, 4'hF, r8, r16);
        chk("gpio_out_af", 32'(out8), 32'hAF);
        rd("out_set", 8'h00, 32'hAF, 32'hAF);
        bus(8'h08, 32'h81, 4'hF, r8, r16);
        rd("out_clr", 8'h00, 32'h2E, 32'h2E);
        bus(8'h0C, 32'hFF, 4'hF, r8, r16);
        chk("gpio_out_d1", 32'(out8), 32'hD1);
        rd("out_tgl", 8'h00, 32'hD1, 32'hD1);
        rd("set_reads0", 8'h04, 32'h0, 32'h0);
        bus(8'h04, 32'hFF, 4'h0, r8, r16);
        rd("strb0_noside", 8'h00, 32'hD1, 32'hD1);

        bus(8'h00, 32'h1234, 4'b0001, r8, r16);
        rd("out_strb1", 8'h00, 32'h34, 32'h34);
        bus(8'h00, 32'h1234, 4'hF, r8, r16);
        rd("out_full", 8'h00, 32'h34, 32'h1234);
        bus(8'h04, 32'hFFFF, 4'b0010, r8, r16);
        rd("set_lane1", 8'h00, 32'h34, 32'hFF34);

        bus(8'h10, 32'hFFFF_FFFF, 4'hF, r8, r16);
        chk("gpio_oe8", 32'(oe8), 32'hFF);
        chk("gpio_oe16", 32'(oe16), 32'hFFFF);
        rd("dir", 8'h10, 32'hFF, 32'hFFFF);

        bus(8'h18, 32'h01, 4'hF, r8, r16);
        bus(8'h1C, 32'h02, 4'hF, r8, r16);
        rd("rise_en", 8'h18, 32'h01, 32'h01);
        rd("stat_quiet", 8'h20, 32'h0, 32'h0);
        gpio_in8 = 8'h01;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("irq_early", 32'({irq8, irq16}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_edge", 32'({irq8, irq16}), 32'b11);
        rd("stat_both", 8'h20, 32'h03, 32'h03);
        bus(8'h20, 32'h01, 4'hF, r8, r16);
        rd("stat_w1c0", 8'h20, 32'h02, 32'h02);
        chk("irq_still", 32'(irq8), 32'd1);
        bus(8'h20, 32'h02, 4'hF, r8, r16);
        chk("irq_cleared", 32'({irq8, irq16}), 32'd0);
        rd("stat_zero", 8'h20, 32'h0, 32'h0);

        gpio_in8 = 8'h00;
        repeat (5) @(negedge clk);
        rd("stat_fall0_ignored", 8'h20, 32'h0, 32'h0);
        gpio_in8 = 8'h01;
        @(posedge clk);
        @(posedge clk);
        bus(8'h20, 32'h01, 4'hF, r8, r16);
        rd("edge_beats_w1c", 8'h20, 32'h01, 32'h01);
        chk("irq_edge_w1c", 32'(irq8), 32'd1);

        rd("unmapped", 8'h40, 32'h0, 32'h0);

        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h100;
        mem_wstrb = 4'h0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready8 || ready16) seen = 1'b1;
        end
        chk("out_of_window_noack", 32'(seen), 32'd0);
        mem_valid = 1'b0;

        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'hFF;
        mem_wstrb = 4'hF;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'({ready8, ready16}), 32'd0);
        chk("rst_mid_out8", 32'(out8), 32'h00);
        chk("rst_mid_out16", 32'(out16), 32'h5A5A);
        chk("rst_mid_irq", 32'({irq8, irq16}), 32'd0);
        chk("rst_mid_oe", 32'({oe16, oe8}), 32'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        reset = 1'b0;
        rd("post_rst_out", 8'h00, 32'h0, 32'h5A5A);
        rd("post_rst_dir", 8'h10, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
